// File: rtl/rs_tx_pkg.sv
// Shared definitions for the RS TX framer: FSM state codes, preamble table and
// derived-size helpers.
package rs_tx_pkg;

  // FSM state codes
  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StPre   = 3'd1;
  localparam logic [2:0] StLen   = 3'd2;
  localparam logic [2:0] StData  = 3'd3;
  localparam logic [2:0] StCrc   = 3'd4;
  localparam logic [2:0] StPad   = 3'd5;
  localparam logic [2:0] StCheck = 3'd6;

  // Preamble byte selected by the latched rate select
  localparam logic [7:0] PRE_TABLE [4] = '{8'h55, 8'hAA, 8'h5A, 8'hA5};

  // Number of check-slot cycles per RS block
  function automatic int unsigned rs_r_calc(input int unsigned n, input int unsigned k,
                                            input int unsigned pad);
    return n - k + pad;
  endfunction

  // Bytes needed to carry a length field of width w
  function automatic int unsigned len_bytes(input int unsigned w);
    return (w + 7) / 8;
  endfunction

endpackage

// File: rtl/crc16_ccitt_byte.sv
// Combinational CRC-16-CCITT (poly 0x1021, MSB first) advanced by one byte.
module crc16_ccitt_byte (
  input  logic [15:0] crc,
  input  logic [7:0]  data,
  output logic [15:0] crc_next
);

  // Bitwise shift-register update over the 8 data bits
  always_comb begin
    logic [15:0] c;
    c = crc ^ {data, 8'h00};
    for (int i = 0; i < 8; i++) begin
      c = c[15] ? ({c[14:0], 1'b0} ^ 16'h1021) : {c[14:0], 1'b0};
    end
    crc_next = c;
  end

endmodule

// File: rtl/rs_tx_framer.sv
// TX framer between the MAC MTL read side and the RS encoder. Serialises input
// words to bytes, prepends preamble and LSB-first length, pads each RS block to
// RS_K data symbols and reserves RS_R check slots, resuming frames across blocks.
// Optional feature macro: RS_TX_FRAME_CRC_EN appends a CRC-16-CCITT (low byte first).
module rs_tx_framer
  import rs_tx_pkg::*;
#(
  parameter int unsigned RS_N     = 255,
  parameter int unsigned RS_K     = 239,
  parameter int unsigned CHK_PAD  = 7,
  parameter int unsigned IN_BYTES = 4,
  parameter int unsigned LEN_W    = 15,
  parameter int unsigned PRE_LEN  = 1,
  parameter int unsigned CNT_W    = 10,
  localparam int unsigned BE_W    = (IN_BYTES > 1) ? $clog2(IN_BYTES) : 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_val,
  input  logic                  i_sof,
  input  logic                  i_eof,
  input  logic [BE_W-1:0]       i_be,
  input  logic [8*IN_BYTES-1:0] i_data,
  output logic                  o_ack,
  input  logic [LEN_W-1:0]      i_frame_len,
  input  logic                  i_frame_len_val,
  input  logic [1:0]            i_rate_sel,
  output logic                  o_sof,
  output logic [7:0]            o_data,
  output logic                  o_rs_data_symbol,
  output logic                  o_rs_check_symbol,
  output logic                  o_underrun
);

  localparam int unsigned RS_R   = rs_r_calc(RS_N, RS_K, CHK_PAD);
  localparam int unsigned LEN_B  = len_bytes(LEN_W);
  localparam int unsigned LEN_BW = 8 * LEN_B;

  logic [2:0]        state_q, state_d, ret_q, ret_d, nxt_pos;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [3:0]        idx_q, idx_d;
  logic [BE_W-1:0]   sel_q, sel_d, last_sel;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [1:0]        rate_q, rate_d;
  logic [LEN_BW-1:0] len_ext;
  logic              start, in_blk;
  logic [7:0]        byte_d;
  logic              sof_d, dsym_d, csym_d, urun_d;

  assign start    = i_val & i_sof & i_frame_len_val;
  assign last_sel = (i_eof && IN_BYTES > 1) ? i_be : BE_W'(IN_BYTES - 1);
  assign len_ext  = LEN_BW'(len_q);
  assign o_ack    = i_val & (state_q == StData) & (sel_q == last_sel);

`ifdef RS_TX_FRAME_CRC_EN
  logic [15:0] crc_q, crc_d, crc_nxt;

  crc16_ccitt_byte u_crc (
    .crc      (crc_q),
    .data     (byte_d),
    .crc_next (crc_nxt)
  );

  // Re-seed on preamble entry, fold in every emitted payload byte
  always_comb begin
    crc_d = crc_q;
    if (state_d == StPre && state_q != StPre) begin
      crc_d = 16'hFFFF;
    end else if (state_q == StData && i_val) begin
      crc_d = crc_nxt;
    end
  end

  // CRC accumulator
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) crc_q <= 16'hFFFF;
    else          crc_q <= crc_d;
  end
`endif

  // Next-state, symbol selection and block accounting
  always_comb begin
    state_d = state_q;
    ret_d   = ret_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    sel_d   = sel_q;
    len_d   = len_q;
    rate_d  = rate_q;
    nxt_pos = state_q;
    in_blk  = 1'b0;
    byte_d  = 8'h00;
    sof_d   = 1'b0;
    dsym_d  = 1'b0;
    csym_d  = 1'b0;
    urun_d  = 1'b0;
    case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StPre;
          idx_d   = '0;
          sel_d   = '0;
          len_d   = i_frame_len;
          rate_d  = i_rate_sel;
        end
      end
      StPre: begin
        in_blk = 1'b1;
        dsym_d = 1'b1;
        byte_d = PRE_TABLE[rate_q];
        sof_d  = (idx_q == 4'd0);
        if (idx_q == 4'(PRE_LEN - 1)) begin
          idx_d   = '0;
          nxt_pos = StLen;
        end else begin
          idx_d = idx_q + 4'd1;
        end
      end
      StLen: begin
        in_blk = 1'b1;
        dsym_d = 1'b1;
        byte_d = 8'(len_ext >> {idx_q, 3'b000});
        if (idx_q == 4'(LEN_B - 1)) begin
          idx_d   = '0;
          sel_d   = '0;
          nxt_pos = StData;
        end else begin
          idx_d = idx_q + 4'd1;
        end
      end
      StData: begin
        in_blk = 1'b1;
        dsym_d = 1'b1;
        if (i_val) begin
          byte_d = 8'(i_data >> {sel_q, 3'b000});
          if (sel_q == last_sel) begin
            sel_d = '0;
            if (i_eof) begin
              idx_d = '0;
`ifdef RS_TX_FRAME_CRC_EN
              nxt_pos = StCrc;
`else
              nxt_pos = StPad;
`endif
            end
          end else begin
            sel_d = sel_q + 1'b1;
          end
        end else begin
          // Starved mid-frame: burn a zero data symbol, keep the lane
          urun_d = 1'b1;
        end
      end
`ifdef RS_TX_FRAME_CRC_EN
      StCrc: begin
        in_blk = 1'b1;
        dsym_d = 1'b1;
        byte_d = idx_q[0] ? crc_q[15:8] : crc_q[7:0];
        if (idx_q[0]) begin
          idx_d   = '0;
          nxt_pos = StPad;
        end else begin
          idx_d = 4'd1;
        end
      end
`endif
      StPad: begin
        in_blk = 1'b1;
        dsym_d = 1'b1;
      end
      StCheck: begin
        csym_d = 1'b1;
        if (cnt_q == CNT_W'(RS_R - 1)) begin
          cnt_d = '0;
          if (ret_q != StIdle) begin
            state_d = ret_q;
          end else if (start) begin
            state_d = StPre;
            idx_d   = '0;
            sel_d   = '0;
            len_d   = i_frame_len;
            rate_d  = i_rate_sel;
          end else begin
            state_d = StIdle;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    // Block boundary: park the frame position (PAD means finished) and go to check slots
    if (in_blk) begin
      if (cnt_q == CNT_W'(RS_K - 1)) begin
        cnt_d   = '0;
        state_d = StCheck;
        ret_d   = (nxt_pos == StPad) ? StIdle : nxt_pos;
      end else begin
        cnt_d   = cnt_q + 1'b1;
        state_d = nxt_pos;
      end
    end
  end

  // State and counters
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= StIdle;
      ret_q   <= StIdle;
      cnt_q   <= '0;
      idx_q   <= '0;
      sel_q   <= '0;
      len_q   <= '0;
      rate_q  <= '0;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      sel_q   <= sel_d;
      len_q   <= len_d;
      rate_q  <= rate_d;
    end
  end

  // Registered symbol outputs
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_data            <= 8'h00;
      o_sof             <= 1'b0;
      o_rs_data_symbol  <= 1'b0;
      o_rs_check_symbol <= 1'b0;
      o_underrun        <= 1'b0;
    end else begin
      o_data            <= byte_d;
      o_sof             <= sof_d;
      o_rs_data_symbol  <= dsym_d;
      o_rs_check_symbol <= csym_d;
      o_underrun        <= urun_d;
    end
  end

endmodule

// File: tb/tb_rs_tx_framer.sv
// Directed bench for rs_tx_framer with default parameters. Output symbols are
// captured each cycle as {underrun, sof, check, data, byte} and compared with a
// stream built from the frame contents. Build with RS_TX_FRAME_CRC_EN to run
// the CRC frame instead of the plain-frame set.
module tb_rs_tx_framer;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_val, i_sof, i_eof;
  logic [1:0]  i_be;
  logic [31:0] i_data;
  logic        o_ack;
  logic [14:0] i_frame_len;
  logic        i_frame_len_val;
  logic [1:0]  i_rate_sel;
  logic        o_sof;
  logic [7:0]  o_data;
  logic        o_rs_data_symbol, o_rs_check_symbol, o_underrun;

  rs_tx_framer u_dut (
    .i_clk             (i_clk),
    .i_rst_n           (i_rst_n),
    .i_val             (i_val),
    .i_sof             (i_sof),
    .i_eof             (i_eof),
    .i_be              (i_be),
    .i_data            (i_data),
    .o_ack             (o_ack),
    .i_frame_len       (i_frame_len),
    .i_frame_len_val   (i_frame_len_val),
    .i_rate_sel        (i_rate_sel),
    .o_sof             (o_sof),
    .o_data            (o_data),
    .o_rs_data_symbol  (o_rs_data_symbol),
    .o_rs_check_symbol (o_rs_check_symbol),
    .o_underrun        (o_underrun)
  );

  always #5 i_clk = ~i_clk;

  int n_tot = 0;
  int n_bad = 0;

  logic [7:0]  pay[$];
  logic [11:0] cap_q[$];
  logic [11:0] exp_q[$];
  logic        cap_en = 1'b0;
  logic [7:0]  pre_tab [4] = '{8'h55, 8'hAA, 8'h5A, 8'hA5};

  always @(negedge i_clk) begin
    if (cap_en) cap_q.push_back({o_underrun, o_sof, o_rs_check_symbol, o_rs_data_symbol, o_data});
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Expected symbol stream for one frame: 239 data symbols per block, 23 check slots after each
  task automatic add_frame(input logic [1:0] rate, input int len_field, input int urun_pos,
                           input int n_extra, input logic [15:0] extra);
    logic [11:0] d[$];
    int blk;
    d.push_back({4'b0101, pre_tab[rate]});
    d.push_back({4'b0001, 8'(len_field)});
    d.push_back({4'b0001, 8'(len_field >> 8)});
    for (int i = 0; i < pay.size(); i++) begin
      if (i == urun_pos) begin
        d.push_back(12'h900);
        d.push_back(12'h900);
      end
      d.push_back({4'b0001, pay[i]});
    end
    for (int i = 0; i < n_extra; i++) d.push_back({4'b0001, 8'(extra >> (8 * i))});
    blk = 0;
    foreach (d[i]) begin
      exp_q.push_back(d[i]);
      blk++;
      if (blk == 239) begin
        repeat (23) exp_q.push_back(12'h200);
        blk = 0;
      end
    end
    if (blk > 0) begin
      while (blk < 239) begin
        exp_q.push_back(12'h100);
        blk++;
      end
      repeat (23) exp_q.push_back(12'h200);
    end
  endtask

  task automatic send_frame(input int len_field, input logic [1:0] rate, input int drop_w);
    int n, nw;
    bit got;
    n  = pay.size();
    nw = (n + 3) / 4;
    for (int w = 0; w < nw; w++) begin
      logic [31:0] word;
      word = '0;
      for (int b = 0; b < 4; b++) if (4 * w + b < n) word[8*b+:8] = pay[4*w+b];
      i_data          = word;
      i_val           = 1'b1;
      i_sof           = (w == 0);
      i_eof           = (w == nw - 1);
      i_be            = (w == nw - 1) ? 2'(n - 1 - 4 * w) : 2'd0;
      i_frame_len     = 15'(len_field);
      i_frame_len_val = 1'b1;
      i_rate_sel      = rate;
      if (w == drop_w) begin
        repeat (2) @(posedge i_clk);
        #1 i_val = 1'b0;
        repeat (2) begin
          @(negedge i_clk);
          check_eq("drop_no_ack", 32'(o_ack), 32'd0);
          @(posedge i_clk);
        end
        #1 i_val = 1'b1;
      end
      got = 1'b0;
      for (int k = 0; k < 3000; k++) begin
        @(negedge i_clk);
        if (o_ack) begin
          got = 1'b1;
          break;
        end
      end
      check_eq("ack_seen", 32'(got), 32'd1);
      if (!got) break;
      @(posedge i_clk);
      #1;
    end
    i_val           = 1'b0;
    i_sof           = 1'b0;
    i_eof           = 1'b0;
    i_frame_len_val = 1'b0;
  endtask

  task automatic strip_cap();
    while (cap_q.size() > 0 && cap_q[0] == 12'h000) void'(cap_q.pop_front());
    while (cap_q.size() > 0 && cap_q[cap_q.size()-1] == 12'h000) void'(cap_q.pop_back());
  endtask

  task automatic compare_stream(input string name);
    int m, b0;
    check_eq({name, "_len"}, 32'(cap_q.size()), 32'(exp_q.size()));
    m = (cap_q.size() < exp_q.size()) ? cap_q.size() : exp_q.size();
    for (int i = 0; i < m; i++) begin
      b0 = n_bad;
      check_eq($sformatf("%s_sym%0d", name, i), 32'(cap_q[i]), 32'(exp_q[i]));
      if (n_bad != b0) break;
    end
  endtask

  task automatic begin_cap();
    cap_q.delete();
    exp_q.delete();
    cap_en = 1'b1;
  endtask

  task automatic end_cap();
    repeat (300) @(posedge i_clk);
    #1 cap_en = 1'b0;
    strip_cap();
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_data"}, 32'(o_data), 32'd0);
    check_eq({tag, "_sof"}, 32'(o_sof), 32'd0);
    check_eq({tag, "_dsym"}, 32'(o_rs_data_symbol), 32'd0);
    check_eq({tag, "_csym"}, 32'(o_rs_check_symbol), 32'd0);
    check_eq({tag, "_urun"}, 32'(o_underrun), 32'd0);
    check_eq({tag, "_ack"}, 32'(o_ack), 32'd0);
  endtask

  initial begin
    i_rst_n = 1'b0;
    i_val = 1'b0; i_sof = 1'b0; i_eof = 1'b0; i_be = '0; i_data = '0;
    i_frame_len = '0; i_frame_len_val = 1'b0; i_rate_sel = '0;
    repeat (2) @(posedge i_clk);
    #1 check_idle_outputs("reset");
    @(negedge i_clk) i_rst_n = 1'b1;
    @(posedge i_clk);
    #1;

`ifndef RS_TX_FRAME_CRC_EN
    // Word without sof at frame start is ignored
    i_val = 1'b1; i_sof = 1'b0; i_frame_len_val = 1'b1; i_data = 32'h11223344;
    repeat (3) begin
      @(negedge i_clk);
      check_eq("nosof_ack", 32'(o_ack), 32'd0);
      check_eq("nosof_dsym", 32'(o_rs_data_symbol), 32'd0);
    end
    @(posedge i_clk);
    #1 i_val = 1'b0; i_frame_len_val = 1'b0;

    // Short frame, one word, be=2
    pay = '{8'hAA, 8'hBB, 8'hCC};
    begin_cap();
    send_frame(3, 2'd0, -1);
    end_cap();
    check_eq("t1_size", 32'(cap_q.size()), 32'd262);
    check_eq("t1_s0", 32'(cap_q[0]), 32'h555);
    check_eq("t1_s1", 32'(cap_q[1]), 32'h103);
    check_eq("t1_s2", 32'(cap_q[2]), 32'h100);
    check_eq("t1_s3", 32'(cap_q[3]), 32'h1AA);
    check_eq("t1_s5", 32'(cap_q[5]), 32'h1CC);
    check_eq("t1_s238", 32'(cap_q[238]), 32'h100);
    check_eq("t1_s239", 32'(cap_q[239]), 32'h200);
    add_frame(2'd0, 3, -1, 0, 16'h0);
    compare_stream("t1");

    // 240-byte frame straddling two blocks
    pay.delete();
    for (int i = 0; i < 240; i++) pay.push_back(8'(i + 1));
    begin_cap();
    send_frame(240, 2'd1, -1);
    end_cap();
    check_eq("t2_s1", 32'(cap_q[1]), 32'h1F0);
    check_eq("t2_s238", 32'(cap_q[238]), 32'h1EC);
    check_eq("t2_s262", 32'(cap_q[262]), 32'h1ED);
    add_frame(2'd1, 240, -1, 0, 16'h0);
    compare_stream("t2");

    // Payload filling block exactly, second frame waiting
    pay.delete();
    for (int i = 0; i < 236; i++) pay.push_back(8'(8'h80 ^ i));
    begin_cap();
    send_frame(236, 2'd0, -1);
    add_frame(2'd0, 236, -1, 0, 16'h0);
    pay = '{8'h01, 8'h02, 8'h03};
    send_frame(3, 2'd3, -1);
    end_cap();
    check_eq("t3_s261", 32'(cap_q[261]), 32'h200);
    check_eq("t3_s262", 32'(cap_q[262]), 32'h5A5);
    add_frame(2'd3, 3, -1, 0, 16'h0);
    compare_stream("t3");

    // i_val dropped for two cycles after lanes 0,1 of the second word
    pay = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17};
    begin_cap();
    send_frame(8, 2'd2, 1);
    end_cap();
    check_eq("t4_u0", 32'(cap_q[9]), 32'h900);
    check_eq("t4_u1", 32'(cap_q[10]), 32'h900);
    check_eq("t4_resume", 32'(cap_q[11]), 32'h116);
    add_frame(2'd2, 8, 6, 0, 16'h0);
    compare_stream("t4");
`endif

    // Reset mid-block, then a clean frame
    i_data = 32'h00CCBBAA; i_val = 1'b1; i_sof = 1'b1; i_eof = 1'b0; i_be = 2'd3;
    i_frame_len = 15'd40; i_frame_len_val = 1'b1; i_rate_sel = 2'd1;
    repeat (5) @(posedge i_clk);
    #2 i_rst_n = 1'b0;
    #1 check_idle_outputs("midrst");
    i_val = 1'b0; i_sof = 1'b0; i_frame_len_val = 1'b0;
    @(negedge i_clk) i_rst_n = 1'b1;
    @(posedge i_clk);
    #1;
    pay = '{8'hAA, 8'hBB, 8'hCC};
    begin_cap();
    send_frame(3, 2'd0, -1);
    end_cap();
    check_eq("t5_s0", 32'(cap_q[0]), 32'h555);
    add_frame(2'd0, 3, -1, 0, 16'h0);
    compare_stream("t5");

`ifdef RS_TX_FRAME_CRC_EN
    // CRC-16-CCITT of "123456789" is 29B1, sent low byte first
    pay = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    begin_cap();
    send_frame(9, 2'd0, -1);
    end_cap();
    check_eq("crc_lo", 32'(cap_q[12]), 32'h1B1);
    check_eq("crc_hi", 32'(cap_q[13]), 32'h129);
    check_eq("crc_pad", 32'(cap_q[14]), 32'h100);
    add_frame(2'd0, 9, -1, 2, 16'h29B1);
    compare_stream("crc");
`endif

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
